// File: rtl/gam_memory_layer_pkg.sv
// GAM shared types, constants and the memory written by the learning layer.
// Node refinement helper used on the update path.
package GAM_package;

    localparam int CLASS_COUNT = 4;
    localparam int NODE_COUNT  = 16;
    localparam int TH_INIT     = 4;
    localparam int M_MAX       = 255;
    localparam int CW          = $clog2(CLASS_COUNT);
    localparam int NW          = $clog2(NODE_COUNT);

    typedef logic [31:0] node_vector_T;

    typedef struct packed {
        node_vector_T W;
        int           Th;
        int           M;
    } node_T;

    typedef struct packed {
        node_T [NODE_COUNT-1:0] node;
    } class_T;

    typedef struct packed {
        class_T [CLASS_COUNT-1:0] classes;
    } memory_T;

    typedef enum logic { LEARNING, RECALL } LEARNING_RECALL_T;
    typedef enum logic { READY, WAIT } READY_WAIT_T;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_SCAN,
        S_UPDATE,
        S_DONE,
        S_RECALL
    } state_T;

    memory_T memory;

    // Winner refinement: bump M, pull each lane toward x by diff/M, widen Th.
    function automatic node_T refine(node_T n, node_vector_T xv, logic [9:0] d);
        node_T r;
        int    m;
        int    dl;
        r = n;
        m = (n.M >= M_MAX) ? M_MAX : n.M + 1;
        for (int l = 0; l < 4; l++) begin
            dl = int'(xv[8*l +: 8]) - int'(n.W[8*l +: 8]);
            r.W[8*l +: 8] = 8'(int'(n.W[8*l +: 8]) + dl / m);
        end
        r.M  = m;
        r.Th = (int'(d) > n.Th) ? int'(d) : n.Th;
        return r;
    endfunction

endpackage

// File: rtl/gam_memory_layer_if.sv
// Input-vector handshake between the node source and the learning layer.
interface gam_memory_layer_if;
    import GAM_package::*;

    node_vector_T     x;
    int               c;
    logic             learning_done;
    LEARNING_RECALL_T learning_recall;
    READY_WAIT_T      ready_wait;

    modport master (
        output x, c, learning_done, learning_recall,
        input  ready_wait
    );

    modport slave (
        input  x, c, learning_done, learning_recall,
        output ready_wait
    );

endinterface

// File: rtl/gam_memory_layer_sad.sv
// Combinational sum of absolute differences over four unsigned 8-bit lanes.
module gam_sad_distance (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [9:0]  d
);

    always_comb begin
        d = '0;
        for (int l = 0; l < 4; l++) begin
            if (a[8*l +: 8] > b[8*l +: 8])
                d = d + 10'(a[8*l +: 8] - b[8*l +: 8]);
            else
                d = d + 10'(b[8*l +: 8] - a[8*l +: 8]);
        end
    end

endmodule

// File: rtl/gam_memory_layer.sv
// GAM learning engine: scans a class for the nearest node, then inserts or refines.
// Optional GAM_NONZERO_CHECK_EN rejects zero x / zero class and adds assertions.
module gam_memory_layer
    import GAM_package::*;
(
    input logic         clk,
    input logic         reset,
    gam_memory_layer_if.slave bus
);

    state_T          state;
    state_T          state_nxt;
    logic            started;
    node_vector_T    cap_x;
    logic [CW-1:0]   cap_c;
    logic            cap_ok;
    logic [NW-1:0]   occ [CLASS_COUNT];
    logic [NW-1:0]   scan_idx;
    logic [NW-1:0]   best_n;
    logic [9:0]      best_d;
    logic [9:0]      sad_d;

    logic            c_valid;
    logic            in_reject;
    logic            in_ok;
    logic [CW-1:0]   in_c;
    logic            capture;
    logic [NW-1:0]   cur_occ;
    logic [NW-1:0]   ins_slot;
    logic            full;
    logic            do_insert;
    node_vector_T    scan_w;
    node_T           win;
    node_T           ins_node;
    node_T           upd_node;

    assign c_valid = (bus.c > 0) && (bus.c < CLASS_COUNT);
    assign in_c    = bus.c[CW-1:0];

`ifdef GAM_NONZERO_CHECK_EN
    assign in_reject = (bus.x == '0) || (bus.c == 0);
`else
    assign in_reject = 1'b0;
`endif

    assign in_ok   = c_valid && !in_reject;
    assign capture = (state == S_READY) && !bus.learning_done
                   && (bus.learning_recall == LEARNING);

    assign cur_occ   = occ[cap_c];
    assign ins_slot  = cur_occ + NW'(1);
    assign full      = (cur_occ == NW'(NODE_COUNT - 1));
    assign scan_w    = memory.classes[cap_c].node[scan_idx].W;
    assign win       = memory.classes[cap_c].node[best_n];
    assign do_insert = (cur_occ == '0) || ((int'(best_d) > win.Th) && !full);
    assign ins_node  = '{W: cap_x, Th: TH_INIT, M: 1};
    assign upd_node  = refine(win, cap_x, best_d);

    gam_sad_distance u_sad (
        .a (cap_x),
        .b (scan_w),
        .d (sad_d)
    );

    assign bus.ready_wait = (state == S_READY) ? READY : WAIT;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (started) state_nxt = S_READY;
            S_READY: begin
                if (bus.learning_done)
                    state_nxt = S_DONE;
                else if (bus.learning_recall == RECALL)
                    state_nxt = S_RECALL;
                else if (in_ok && occ[in_c] != '0)
                    state_nxt = S_SCAN;
                else
                    state_nxt = S_UPDATE;
            end
            S_SCAN:   if (scan_idx == cur_occ) state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_READY;
            S_DONE:   state_nxt = S_DONE;
            S_RECALL: if (bus.learning_recall == LEARNING) state_nxt = S_READY;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            started  <= 1'b0;
            cap_x    <= '0;
            cap_c    <= '0;
            cap_ok   <= 1'b0;
            scan_idx <= '0;
            best_n   <= '0;
            best_d   <= '0;
            for (int i = 0; i < CLASS_COUNT; i++)
                occ[i] <= '0;
            memory   <= '0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (capture) begin
`ifdef GAM_NONZERO_CHECK_EN
                assert (!in_reject)
                    else $error("gam_memory_layer: zero x or class rejected");
`endif
                cap_x    <= bus.x;
                cap_c    <= in_c;
                cap_ok   <= in_ok;
                scan_idx <= NW'(1);
            end
            // Strict less-than keeps the lowest index on ties.
            if (state == S_SCAN) begin
                if (scan_idx == NW'(1) || sad_d < best_d) begin
                    best_d <= sad_d;
                    best_n <= scan_idx;
                end
                scan_idx <= scan_idx + NW'(1);
            end
            if (state == S_UPDATE && cap_ok) begin
                if (do_insert) begin
                    memory.classes[cap_c].node[ins_slot] <= ins_node;
                    occ[cap_c] <= ins_slot;
                end else begin
                    memory.classes[cap_c].node[best_n] <= upd_node;
                end
            end
        end
    end

`ifdef GAM_NONZERO_CHECK_EN
    logic nz_ok;

    always_comb begin
        nz_ok = 1'b1;
        for (int ci = 1; ci < CLASS_COUNT; ci++)
            for (int ni = 1; ni < NODE_COUNT; ni++)
                if (NW'(ni) <= occ[ci] && memory.classes[ci].node[ni].W == '0)
                    nz_ok = 1'b0;
    end

    a_nonzero_nodes: assert property (@(posedge clk) disable iff (!reset) nz_ok)
        else $error("gam_memory_layer: occupied node with zero weight");
`endif

endmodule

// File: tb/tb_gam_memory_layer.sv
// Self-checking bench for gam_memory_layer with a reference-model scoreboard.
module tb_gam_memory_layer;
    import GAM_package::*;

    typedef struct {
        int      lat;
        int      c;
        memory_T mem;
    } exp_t;

    logic    clk = 1'b0;
    logic    reset = 1'b0;
    int      checks = 0;
    int      errors = 0;
    exp_t    sb [$];
    memory_T m_exp;
    int      mocc [CLASS_COUNT];

    gam_memory_layer_if ifc ();

    gam_memory_layer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    function automatic int tb_sad(logic [31:0] a, logic [31:0] b);
        int s = 0;
        int t;
        for (int l = 0; l < 4; l++) begin
            t = int'(a[8*l +: 8]) - int'(b[8*l +: 8]);
            s += (t < 0) ? -t : t;
        end
        return s;
    endfunction

    task automatic model_clear();
        m_exp = '0;
        for (int i = 0; i < CLASS_COUNT; i++) mocc[i] = 0;
    endtask

    task automatic model_apply(input logic [31:0] xv, input int cv, output int lat);
        int best, bd, d, m, old, dl;
        node_T n;
        lat = 2;
        if (cv < 1 || cv >= CLASS_COUNT) return;
`ifdef GAM_NONZERO_CHECK_EN
        if (xv == 0) return;
`endif
        lat = 2 + mocc[cv];
        best = 0;
        bd = 1 << 30;
        for (int k = 1; k <= mocc[cv]; k++) begin
            d = tb_sad(xv, m_exp.classes[cv].node[k].W);
            if (d < bd) begin
                bd = d;
                best = k;
            end
        end
        if (mocc[cv] == 0 ||
            (bd > m_exp.classes[cv].node[best].Th && mocc[cv] < NODE_COUNT - 1)) begin
            mocc[cv]++;
            m_exp.classes[cv].node[mocc[cv]] = '{W: xv, Th: TH_INIT, M: 1};
        end else begin
            n = m_exp.classes[cv].node[best];
            m = n.M + 1;
            if (m > M_MAX) m = M_MAX;
            for (int l = 0; l < 4; l++) begin
                old = int'(n.W[8*l +: 8]);
                dl = int'(xv[8*l +: 8]) - old;
                n.W[8*l +: 8] = 8'(old + dl / m);
            end
            n.M = m;
            if (bd > n.Th) n.Th = bd;
            m_exp.classes[cv].node[best] = n;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (ifc.ready_wait !== READY && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (ifc.ready_wait === READY);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_ready: ready_wait=%0d after %0d cycles, required READY", ifc.ready_wait, n);
        end
    endtask

    task automatic send(input logic [31:0] xv, input int cv);
        exp_t e;
        int   lat;
        bit   ok;
        bit   shown;
        ifc.x = xv;
        ifc.c = cv;
        wait_ready(ok);
        if (!ok) return;
        model_apply(xv, cv, e.lat);
        e.c = cv;
        e.mem = m_exp;
        sb.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ifc.ready_wait !== READY && lat < 100);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL latency x=%h c=%0d: got %0d cycles, required %0d", xv, cv, lat, e.lat);
        end
        checks++;
        if (GAM_package::memory !== e.mem) begin
            errors++;
            shown = 0;
            for (int ci = 0; ci < CLASS_COUNT; ci++)
                for (int ni = 0; ni < NODE_COUNT; ni++)
                    if (!shown && GAM_package::memory.classes[ci].node[ni] !== e.mem.classes[ci].node[ni]) begin
                        shown = 1;
                        $display("FAIL memory x=%h c=%0d node[%0d][%0d]: got W=%h Th=%0d M=%0d, required W=%h Th=%0d M=%0d",
                                 xv, cv, ci, ni,
                                 GAM_package::memory.classes[ci].node[ni].W,
                                 GAM_package::memory.classes[ci].node[ni].Th,
                                 GAM_package::memory.classes[ci].node[ni].M,
                                 e.mem.classes[ci].node[ni].W,
                                 e.mem.classes[ci].node[ni].Th,
                                 e.mem.classes[ci].node[ni].M);
                    end
        end
    endtask

    task automatic test_reset();
        ifc.x = '0;
        ifc.c = 0;
        ifc.learning_done = 1'b0;
        ifc.learning_recall = LEARNING;
        reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.ready_wait !== WAIT) begin
            errors++;
            $display("FAIL reset_ready: got %0d, required WAIT", ifc.ready_wait);
        end
        checks++;
        if (GAM_package::memory !== '0) begin
            errors++;
            $display("FAIL reset_memory: memory not cleared");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc.ready_wait !== WAIT) begin
            errors++;
            $display("FAIL first_edge: got %0d, required WAIT", ifc.ready_wait);
        end
        @(negedge clk);
        checks++;
        if (ifc.ready_wait !== READY) begin
            errors++;
            $display("FAIL second_edge: got %0d, required READY", ifc.ready_wait);
        end
    endtask

    task automatic test_insert();
        send(32'h0000_0003, 1);
        checks++;
        if (GAM_package::memory.classes[1].node[1] !== node_T'({32'h3, 32'd4, 32'd1})) begin
            errors++;
            $display("FAIL insert_first: got %h, required W=3 Th=4 M=1", GAM_package::memory.classes[1].node[1]);
        end
        send(32'h0000_0400, 1);
        checks++;
        if (GAM_package::memory.classes[1].node[2].W !== 32'h0000_0400) begin
            errors++;
            $display("FAIL insert_second: got W=%h, required 00000400", GAM_package::memory.classes[1].node[2].W);
        end
        send(32'h0007_0005, 1);
        checks++;
        if (GAM_package::memory.classes[1].node[3].W !== 32'h0007_0005) begin
            errors++;
            $display("FAIL insert_third: got W=%h, required 00070005", GAM_package::memory.classes[1].node[3].W);
        end
        send(32'h0000_0101, 1);
        checks++;
        if (GAM_package::memory.classes[1].node[1] !== node_T'({32'h2, 32'd4, 32'd2})) begin
            errors++;
            $display("FAIL update_winner: got %h, required W=2 Th=4 M=2", GAM_package::memory.classes[1].node[1]);
        end
        checks++;
        if (GAM_package::memory.classes[1].node[4] !== '0) begin
            errors++;
            $display("FAIL no_insert: node[4] got %h, required 0", GAM_package::memory.classes[1].node[4]);
        end
    endtask

    task automatic test_recall();
        memory_T snap;
        bit ok;
        bit bad = 0;
        ifc.learning_recall = RECALL;
        wait_ready(ok);
        snap = GAM_package::memory;
        ifc.x = 32'h1234_5678;
        ifc.c = 2;
        repeat (6) begin
            @(negedge clk);
            if (ifc.ready_wait !== WAIT || GAM_package::memory !== snap) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL recall_hold: ready_wait=%0d, required WAIT with frozen memory", ifc.ready_wait);
        end
        ifc.learning_recall = LEARNING;
        wait_ready(ok);
        send(32'h0000_0203, 1);
    endtask

    task automatic test_full_class();
        for (int i = 1; i <= NODE_COUNT; i++)
            send({16'h0, 8'(i * 16), 8'(i * 16)}, 2);
        send(32'hFFFF_FFFF, 2);
    endtask

    task automatic test_random();
        logic [31:0] xv;
        for (int i = 0; i < 12; i++) begin
            xv = {5'd0, 3'($urandom_range(0, 7)), 5'd0, 3'($urandom_range(0, 7)),
                  5'd0, 3'($urandom_range(0, 7)), 5'd0, 3'($urandom_range(0, 7))};
            send(xv, int'($urandom_range(0, 4)));
        end
        send(32'h0101_0101, -1);
    endtask

    task automatic test_done();
        memory_T snap;
        bit ok;
        bit bad = 0;
        ifc.learning_done = 1'b1;
        ifc.x = 32'h0505_0505;
        ifc.c = 1;
        wait_ready(ok);
        snap = GAM_package::memory;
        repeat (10) begin
            @(negedge clk);
            if (ifc.ready_wait !== WAIT || GAM_package::memory !== snap) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL done_hold: ready_wait=%0d, required WAIT with unchanged memory", ifc.ready_wait);
        end
        ifc.learning_done = 1'b0;
    endtask

    task automatic test_reset_scan();
        bit ok;
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send(32'h0000_0003, 1);
        send(32'h0000_0400, 1);
        send(32'h0007_0005, 1);
        ifc.x = 32'h0000_0101;
        ifc.c = 1;
        wait_ready(ok);
        @(negedge clk);
        checks++;
        if (dut.state !== S_SCAN) begin
            errors++;
            $display("FAIL scan_entry: got state %0d, required SCAN", dut.state);
        end
        reset = 1'b0;
        #1;
        model_clear();
        checks++;
        if (ifc.ready_wait !== WAIT || dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_scan_state: ready=%0d state=%0d, required WAIT/IDLE", ifc.ready_wait, dut.state);
        end
        checks++;
        if (GAM_package::memory !== '0) begin
            errors++;
            $display("FAIL reset_scan_memory: memory not cleared");
        end
        @(negedge clk);
        reset = 1'b1;
        send(32'h0000_0009, 3);
    endtask

`ifdef GAM_NONZERO_CHECK_EN
    task automatic test_nonzero();
        memory_T snap;
        snap = GAM_package::memory;
        send(32'h0, 1);
        checks++;
        if (GAM_package::memory !== snap) begin
            errors++;
            $display("FAIL nonzero_reject: memory changed on zero x");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_insert();
        test_recall();
        test_full_class();
        test_random();
        test_done();
        test_reset_scan();
`ifdef GAM_NONZERO_CHECK_EN
        test_nonzero();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gam_memory_layer.md
# gam_memory_layer

Learning engine of the GAM (General Associative Memory) core. Accepts one node vector `x` per handshake, tagged with a class index `c`. For each input it either inserts a new prototype node into that class's memory or refines the nearest existing node: weight, threshold and match count. The shared `memory` structure it writes is read by the recall stage (`auto_associative_recall`).

## Interface
Parameters (constants in `GAM_package`):
- `CLASS_COUNT`, default 4: class slots. Class indices 1..CLASS_COUNT-1 are valid; index 0 is unused.
- `NODE_COUNT`, default 16: node slots per class. Slots 1..NODE_COUNT-1 are usable; slot 0 is unused.
- `TH_INIT`, default 4: threshold given to a newly inserted node.
- `M_MAX`, default 255: saturation value of match count M.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `x`  in  32 (`node_vector_T`)  input vector, four unsigned 8-bit lanes; lane0 = bits[7:0].
- `c`  in  32 (int)  class index of `x`.
- `learning_done`  in  1  high means no further inputs will be presented.
- `learning_recall`  in  `LEARNING_RECALL_T` {LEARNING, RECALL}  selects the operating mode.
- `ready_wait`  out  `READY_WAIT_T` {READY, WAIT}  handshake output.
- Side output: the package variable `memory` (`memory.classes[c].node[n].{W,Th,M}`), written only by this block.

## Operation
- Node fields:
  - W: 32-bit vector.
  - Th: int threshold.
  - M: int match count.
  - Per-class occupancy counter `occ[c]` ranges 0..NODE_COUNT-1.
- Distance `d` is the sum of absolute differences over the 4 lanes, giving a 10-bit unsigned value.
- Learning rule for a captured (x, c):
  - If `occ[c]==0`, insert.
  - Otherwise find the winner w = argmin d(x, W_n) over n = 1..occ[c]. On ties the lowest index wins.
  - If d_min > Th_w and the class is not full, insert at slot occ[c]+1 with W=x, Th=TH_INIT, M=1, then increment occ[c].
  - Otherwise update the winner:
    - M_w = min(M_w+1, M_MAX).
    - Each lane: W += (x_lane − W_lane)/M_new, using signed division truncated toward zero.
    - Th_w = max(Th_w, d_min).
- If c is out of range (0 or ≥ CLASS_COUNT), the input is discarded with no memory change.
- States:
  - IDLE: entered on reset. ready_wait=WAIT. Goes to READY on the next clock.
  - READY: lasts one cycle, ready_wait=READY. At the closing edge:
    - if learning_done=1 → DONE;
    - else if learning_recall=RECALL → RECALL;
    - else capture x and c → SCAN.
  - SCAN: ready_wait=WAIT. Compares one node per cycle over occ[c] cycles; 0 cycles if the class is empty.
  - UPDATE: one cycle. Performs the insert or update, then → READY.
  - DONE: ready_wait=WAIT. Holds until reset.
  - RECALL: ready_wait=WAIT. Memory is frozen. Returns to READY when learning_recall=LEARNING.
- `ready_wait` must toggle once per input, because the source drives `x` on the change of `ready_wait`.

## Timing
- Reset, asynchronous and active-low, sets:
  - state=IDLE, ready_wait=WAIT;
  - all occ=0;
  - every node W=0, Th=0, M=0.
- Reset asserted mid-SCAN or mid-UPDATE aborts the operation with no partial write.
- First READY appears 2 edges after reset deasserts: IDLE, then READY.
- `x`, `c` and `learning_done` are sampled only at the edge that ends READY. They must be stable before that edge.
- Per-input latency, READY to next READY: 1 + occ[c] + 1 cycles.
- A full class (occ = NODE_COUNT−1) always takes the update path.

## Configuration
- `GAM_NONZERO_CHECK_EN`, defined:
  - a captured x==0 or c==0 is rejected with no memory change, and the block returns to READY;
  - an immediate assertion reports an error;
  - a concurrent assertion checks that every occupied node has W≠0.
- Undefined: zero values are processed by the normal rule, and no assertions are compiled.

## Structure
- `GAM_package` holds:
  - types `node_vector_T`, `node_T` {W, Th, M}, `class_T`, `memory_T`;
  - enums `LEARNING_RECALL_T` and `READY_WAIT_T`;
  - constants CLASS_COUNT, NODE_COUNT, TH_INIT and M_MAX;
  - the `memory` variable.
- Sub-module `gam_sad_distance`: a combinational 4-lane SAD with 32-bit inputs and a 10-bit output, instantiated once in SCAN.

## Test plan
- Reset → ready_wait=WAIT and memory all zero. After reset deasserts, READY appears on the 2nd edge.
- Class 1, x=0x00000003 into an empty class → node[1]: W=0x00000003, Th=4, M=1; occ=1.
- Then x=0x00000400 (d=7>4) → node[2] inserted with W=0x00000400. Then x=0x00070005 (d_min=9) → node[3] inserted.
- Then x=0x00000101: d = 3 / 4 / 12, so winner node[1] → node[1]: W=0x00000002, M=2, Th=4; occ stays 3.
- Assert learning_done at a READY edge → DONE; ready_wait stays WAIT and memory is unchanged for 10 cycles.
- Pull reset low during SCAN → immediate IDLE and cleared memory. With `GAM_NONZERO_CHECK_EN` defined, x=0 is rejected and memory is unchanged.
